ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit: the initiator side of the instruction-memory read interface.
- Holds the PC and drives the word address to the combinational instruction memory, which returns the addressed word in the same cycle.
- Registers the returned instruction into an IF/ID output register with valid/ready handshake toward decode.
- Supports stall, redirect (branch/jump/exception target) with flush, and a fetch counter.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; base of the instruction memory window.
- ADDR_W, 12, instruction-memory word-address width (memory depth 2^ADDR_W words).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- im_addr  output  ADDR_W  word address to instruction memory.
- im_instr  input  32  instruction word returned combinationally for im_addr.
- stall  input  1  hazard stall from the pipeline; PC holds and no new fetch is issued.
- redir_valid  input  1  redirect request, one-cycle pulse or level.
- redir_pc  input  32  redirect target PC.
- d_valid  output  1  IF/ID register holds a valid instruction.
- d_ready  input  1  decode accepts the IF/ID contents this cycle.
- d_instr  output  32  fetched instruction.
- d_pc  output  32  PC of d_instr.
- d_pc4  output  32  d_pc + 4.
- fetch_cnt  output  32  count of instructions loaded into IF/ID since reset.

Behaviour:
- The only clock is clk; reset is synchronous and active-high on port reset, sampled on the clk rising edge.
- Reset values:
  - pc = PC_RESET
  - d_valid = 0
  - d_instr = 0
  - d_pc = PC_RESET
  - d_pc4 = PC_RESET + 4
  - fetch_cnt = 0
- im_addr = ((pc - PC_RESET) >> 2) truncated to ADDR_W bits. Purely combinational from the pc register.
- Derived signals:
  - adv = !d_valid || d_ready (IF/ID slot is free or being drained).
  - go = adv && !stall && !redir_valid.
- Per-edge priority:
  1. reset.
  2. redir_valid: pc <= redir_pc and d_valid <= 0 (flush). No delay slot. fetch_cnt unchanged. Overrides stall and d_ready.
  3. go: d_instr <= im_instr, d_pc <= pc, d_pc4 <= pc + 4, d_valid <= 1, pc <= pc + 4, fetch_cnt <= fetch_cnt + 1.
  4. adv && stall: d_valid <= 0 (bubble), pc holds, d_instr/d_pc hold.
  5. Otherwise (d_valid && !d_ready): everything holds. d_instr, d_pc and d_valid must stay stable while unaccepted.
- Latency:
  - Instruction at pc appears on d_instr one cycle after the edge where pc became valid.
  - Sustained throughput: 1 instruction/cycle when !stall and d_ready.
- Redirect is honoured in the cycle it is asserted, even if the output is blocked. The blocked instruction is discarded.
- Redirect asserted during reset is ignored.
- Wrap-around:
  - pc + 4 wraps modulo 2^32.
  - im_addr wraps modulo 2^ADDR_W; without the optional feature, no out-of-window detection.
  - fetch_cnt wraps modulo 2^32.
- pc[1:0] nonzero is not corrected; im_addr simply drops those bits.

Optional Feature:
- Macro: IFU_FETCH_EXC_EN.
- When defined:
  - Adds output d_exc (1 bit, reset 0), loaded alongside d_instr.
  - d_exc = 1 when pc[1:0] != 0, or pc < PC_RESET, or pc >= PC_RESET + 4*2^ADDR_W.
  - On such a fetch, d_instr is loaded with 32'h0000_0000 (nop) instead of im_instr. d_pc still records the faulting pc.
  - fetch_cnt still increments.
- When undefined: no d_exc port, no checks, im_instr is always loaded.

Decomposition:
- Shared package: PC_RESET default (32'h0000_3000), NOP encoding 32'h0, the instruction word width (32), and the IF/ID bundle fields (instr, pc, pc4, exc).
- No sub-module is required. The IF/ID register may optionally be factored as pipe_reg_ifid.

Test Plan:
- Reset then run, d_ready=1, memory word i = 32'h1000_0000+i -> d_pc sequence 0x3000, 0x3004, 0x3008, d_instr 0x10000000, 0x10000001, ...; fetch_cnt = 3 after 3 loads.
- stall held 2 cycles at pc=0x3008 -> d_valid=0 for 2 cycles; im_addr stays 2; resume delivers 0x3008 exactly once.
- d_ready=0 for 3 cycles with d_pc=0x3004 -> d_instr/d_pc/d_valid stable; pc stays 0x3008; no instruction skipped or duplicated after release.
- redir_valid with redir_pc=0x3100 while d_valid=1 and d_ready=0 -> next cycle d_valid=0; following cycle d_pc=0x3100, d_instr = word 0x40.
- reset asserted mid-run together with redir_valid -> pc=0x3000, d_valid=0, fetch_cnt=0.
- With IFU_FETCH_EXC_EN: redir_pc=0x3002 -> d_exc=1, d_instr=0, d_pc=0x3002. redir_pc=0x7000 (ADDR_W=12) -> d_exc=1.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module      : ifu_fetch_pkg
// Description : Shared constants and IF/ID bundle type for the fetch unit.
//               Optional build macro: IFU_FETCH_EXC_EN (adds the exc field).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

    localparam int          c_instr_w          = 32;
    localparam logic [31:0] c_pc_reset_default = 32'h0000_3000;
    localparam logic [31:0] c_nop              = 32'h0000_0000;

    typedef struct packed {
        logic [c_instr_w-1:0] instr;
        logic [31:0]          pc;
        logic [31:0]          pc4;
`ifdef IFU_FETCH_EXC_EN
        logic                 exc;
`endif
    } ifid_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_fetch_if.sv
// ============================================================================
// Module      : ifu_fetch_if
// Description : Instruction-memory, pipeline-control and IF/ID signal bundle.
//               Optional build macro: IFU_FETCH_EXC_EN (adds d_exc).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifu_fetch_if #(
    parameter int ADDR_W = 12
);
    import ifu_fetch_pkg::*;

    logic [ADDR_W-1:0]    im_addr;
    logic [c_instr_w-1:0] im_instr;
    logic                 stall;
    logic                 redir_valid;
    logic [31:0]          redir_pc;
    logic                 d_valid;
    logic                 d_ready;
    logic [c_instr_w-1:0] d_instr;
    logic [31:0]          d_pc;
    logic [31:0]          d_pc4;
    logic [31:0]          fetch_cnt;
`ifdef IFU_FETCH_EXC_EN
    logic                 d_exc;
`endif

    // Fetch unit side
    modport master (
`ifdef IFU_FETCH_EXC_EN
        output d_exc,
`endif
        output im_addr, d_valid, d_instr, d_pc, d_pc4, fetch_cnt,
        input  im_instr, stall, redir_valid, redir_pc, d_ready
    );

    // Memory / pipeline side
    modport slave (
`ifdef IFU_FETCH_EXC_EN
        input  d_exc,
`endif
        input  im_addr, d_valid, d_instr, d_pc, d_pc4, fetch_cnt,
        output im_instr, stall, redir_valid, redir_pc, d_ready
    );

endinterface

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch unit - PC, instruction-memory addressing and
//               IF/ID register with valid/ready, stall, redirect and counter.
//               Optional build macro: IFU_FETCH_EXC_EN (fetch fault detection).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = c_pc_reset_default,
    parameter int          ADDR_W   = 12
) (
    input  wire logic  clk,
    input  wire logic  reset,
    ifu_fetch_if.master bus
);

    logic [31:0] r_pc;
    logic        r_valid;
    ifid_t       r_ifid;
    logic [31:0] r_cnt;

    logic        w_adv;
    logic        w_go;
    ifid_t       w_load;

    assign w_adv = !r_valid || bus.d_ready;
    assign w_go  = w_adv && !bus.stall && !bus.redir_valid;

    assign bus.im_addr = ADDR_W'((r_pc - PC_RESET) >> 2);

`ifdef IFU_FETCH_EXC_EN
    // 33-bit bound so a window ending at 2^32 still compares correctly
    localparam logic [32:0] c_pc_end = {1'b0, PC_RESET} + (33'd1 << (ADDR_W + 2));

    logic w_exc;
    assign w_exc = (r_pc[1:0] != 2'b00) || (r_pc < PC_RESET) ||
                   ({1'b0, r_pc} >= c_pc_end);
`endif

    always_comb begin
        w_load.instr = bus.im_instr;
        w_load.pc    = r_pc;
        w_load.pc4   = next_pc(r_pc);
`ifdef IFU_FETCH_EXC_EN
        w_load.exc   = w_exc;
        if (w_exc) begin
            w_load.instr = c_nop;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= PC_RESET;
            r_valid      <= 1'b0;
            r_ifid.instr <= c_nop;
            r_ifid.pc    <= PC_RESET;
            r_ifid.pc4   <= next_pc(PC_RESET);
`ifdef IFU_FETCH_EXC_EN
            r_ifid.exc   <= 1'b0;
`endif
            r_cnt        <= 32'd0;
        end else if (bus.redir_valid) begin
            // Flush: any blocked instruction is dropped, no delay slot
            r_pc    <= bus.redir_pc;
            r_valid <= 1'b0;
        end else if (w_go) begin
            r_ifid  <= w_load;
            r_valid <= 1'b1;
            r_pc    <= next_pc(r_pc);
            r_cnt   <= r_cnt + 32'd1;
        end else if (w_adv) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.d_valid   = r_valid;
    assign bus.d_instr   = r_ifid.instr;
    assign bus.d_pc      = r_ifid.pc;
    assign bus.d_pc4     = r_ifid.pc4;
    assign bus.fetch_cnt = r_cnt;
`ifdef IFU_FETCH_EXC_EN
    assign bus.d_exc     = r_ifid.exc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch against a behavioural model.
//               Optional build macro: IFU_FETCH_EXC_EN (checks d_exc).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    localparam logic [31:0] c_pcr = 32'h0000_3000;
    localparam int          c_aw  = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifu_fetch_if #(.ADDR_W(c_aw)) bus ();

    ifu_fetch #(.PC_RESET(c_pcr), .ADDR_W(c_aw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:(1<<c_aw)-1];
    assign bus.im_instr = mem[bus.im_addr];

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic        m_known = 1'b0;
    logic [31:0] m_pc, m_instr, m_dpc, m_cnt;
    logic        m_valid, m_exc;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] idx;
        idx = ((pc - c_pcr) >> 2) % 32'd4096;
        return 32'h1000_0000 + idx;
    endfunction

    function automatic logic out_of_window(input logic [31:0] pc);
        return (pc % 32'd4 != 0) || (pc < c_pcr) || (pc >= c_pcr + 32'd16384);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic rst_i, input logic st, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        logic free;
        reset           = rst_i;
        bus.stall       = st;
        bus.redir_valid = rv;
        bus.redir_pc    = rpc;
        bus.d_ready     = rdy;
        #1;
        if (m_known) check("im_addr", 32'(bus.im_addr), ((m_pc - c_pcr) >> 2) % 32'd4096);
        @(posedge clk);
        free = !m_valid || rdy;
        if (rst_i) begin
            m_known = 1'b1;
            m_pc = c_pcr; m_valid = 1'b0; m_instr = 32'h0;
            m_dpc = c_pcr; m_cnt = 32'h0; m_exc = 1'b0;
        end else if (rv) begin
            m_pc = rpc; m_valid = 1'b0;
        end else if (free && !st) begin
`ifdef IFU_FETCH_EXC_EN
            m_exc = out_of_window(m_pc);
`else
            m_exc = 1'b0;
`endif
            m_instr = m_exc ? 32'h0 : word_at(m_pc);
            m_dpc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end else if (free) begin
            m_valid = 1'b0;
        end
        #1;
        if (m_known) begin
            check("d_valid",   32'(bus.d_valid), 32'(m_valid));
            check("d_instr",   bus.d_instr,      m_instr);
            check("d_pc",      bus.d_pc,         m_dpc);
            check("d_pc4",     bus.d_pc4,        m_dpc + 32'd4);
            check("fetch_cnt", bus.fetch_cnt,    m_cnt);
`ifdef IFU_FETCH_EXC_EN
            check("d_exc",     32'(bus.d_exc),   32'(m_exc));
`endif
        end
    endtask

    initial begin
        logic        r_rst, r_st, r_rv, r_rdy;
        logic [31:0] r_rpc;

        for (int i = 0; i < (1 << c_aw); i++) mem[i] = 32'h1000_0000 + 32'(i);

        // Reset, then run with decode always ready
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("rst_fetch_cnt", bus.fetch_cnt, 32'h0);
        step(0, 0, 0, 0, 1);
        check("plan_pc0", bus.d_pc, 32'h3000);
        step(0, 0, 0, 0, 1);
        check("plan_instr1", bus.d_instr, 32'h1000_0001);

        // Stall two cycles at pc=0x3008
        step(0, 1, 0, 0, 1);
        check("stall_bubble", 32'(bus.d_valid), 32'h0);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("resume_pc", bus.d_pc, 32'h3008);

        // Decode back-pressure for three cycles, then release
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Redirect while output is blocked
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h3100, 0);
        check("redir_flush", 32'(bus.d_valid), 32'h0);
        step(0, 0, 0, 0, 1);
        check("redir_pc", bus.d_pc, 32'h3100);
        check("redir_instr", bus.d_instr, 32'h1000_0040);

        // Reset together with a redirect
        step(1, 0, 1, 32'h3500, 1);
        check("rst_redir_cnt", bus.fetch_cnt, 32'h0);
        step(0, 0, 0, 0, 1);
        check("rst_redir_pc", bus.d_pc, 32'h3000);

        // PC wrap-around at 2^32
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("wrap_pc", bus.d_pc, 32'h0);

`ifdef IFU_FETCH_EXC_EN
        step(0, 0, 1, 32'h3002, 1);
        step(0, 0, 0, 0, 1);
        check("exc_misalign", 32'(bus.d_exc), 32'h1);
        check("exc_nop", bus.d_instr, 32'h0);
        check("exc_pc", bus.d_pc, 32'h3002);
        step(0, 0, 1, 32'h7000, 1);
        step(0, 0, 0, 0, 1);
        check("exc_above", 32'(bus.d_exc), 32'h1);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 99) < 15);
            r_rv  = ($urandom_range(0, 99) < 8);
            r_rdy = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 9) == 0) r_rpc = $urandom();
            else r_rpc = c_pcr + (32'($urandom_range(0, 4095)) << 2);
            step(r_rst, r_st, r_rv, r_rpc, r_rdy);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
